// File: rtl/i2c_bypass_nport.sv
// ----------------------------------------------------------------------------
// i2c_bypass_nport
//   Transparent multi-segment I2C repeater. NPORT open-drain segments are
//   joined through the FPGA with no master/slave notion. SCL and SDA each run
//   their own arbiter: the first enabled port seen low becomes the owner and
//   every other enabled port is pulled low until the owner lets go. After a
//   release the arbiter waits HOLD_CYC cycles so the pull-ups can restore the
//   lines before it senses again. A stuck-low owner is force-released after
//   TOUT_CYC cycles (0 disables this).
//
// Ports
//   clk        : system clock
//   reset_n    : synchronous reset, active low
//   port_en    : per-port enable; a disabled port is never sensed or driven
//   scl, sda   : open-drain I2C pins (driven 0 or Z only; pull-ups required)
//   scl_busy   : SCL arbiter not idle
//   sda_busy   : SDA arbiter not idle
//   scl_owner  : index of the port owning SCL (valid while scl_busy)
//   sda_owner  : index of the port owning SDA (valid while sda_busy)
//   tout_pulse : one-cycle pulse on forced release, [0] = SCL, [1] = SDA
// ----------------------------------------------------------------------------
module i2c_bypass_nport #(
  parameter int NPORT    = 2,
  parameter int FILT_LEN = 3,
  parameter int HOLD_CYC = 50,
  parameter int TOUT_CYC = 65535,
  localparam int OW      = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NPORT-1:0]  port_en,
  inout  wire  [NPORT-1:0]  scl,
  inout  wire  [NPORT-1:0]  sda,
  output logic              scl_busy,
  output logic              sda_busy,
  output logic [OW-1:0]     scl_owner,
  output logic [OW-1:0]     sda_owner,
  output logic [1:0]        tout_pulse
);

  // Line 0 is SCL, line 1 is SDA; both use identical logic.
  localparam int NL = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  logic [NPORT-1:0] pin_in [NL];

  logic [NPORT-1:0] s1_q   [NL];
  logic [NPORT-1:0] s1_d   [NL];
  logic [NPORT-1:0] s2_q   [NL];
  logic [NPORT-1:0] s2_d   [NL];
  logic [NPORT-1:0] f_q    [NL];
  logic [NPORT-1:0] f_d    [NL];
  logic [3:0]       fcnt_q [NL][NPORT];
  logic [3:0]       fcnt_d [NL][NPORT];

  state_t           state_q [NL];
  state_t           state_d [NL];
  logic [OW-1:0]    owner_q [NL];
  logic [OW-1:0]    owner_d [NL];
  logic [NPORT-1:0] drv_q   [NL];
  logic [NPORT-1:0] drv_d   [NL];
  logic [31:0]      lcnt_q  [NL];
  logic [31:0]      lcnt_d  [NL];
  logic [31:0]      hcnt_q  [NL];
  logic [31:0]      hcnt_d  [NL];
  logic [1:0]       tout_q;
  logic [1:0]       tout_d;

  logic [NPORT-1:0] req  [NL];
  logic [OW-1:0]    cand [NL];

  assign pin_in[0] = scl;
  assign pin_in[1] = sda;

  always_comb begin
    tout_d = 2'b00;
    for (int l = 0; l < NL; l++) begin
      // Synchroniser input. A pin we are driving low reads as high: that low
      // is our own echo, and masking it keeps the arbiter from re-capturing
      // a driven segment once the hold window ends.
      s1_d[l] = pin_in[l] | drv_q[l];
      s2_d[l] = s1_q[l];

      // Stability filter: f follows s2 only after FILT_LEN equal samples.
      f_d[l] = f_q[l];
      for (int i = 0; i < NPORT; i++) begin
        fcnt_d[l][i] = 4'd0;
        if (s2_q[l][i] != f_q[l][i]) begin
          if (fcnt_q[l][i] >= 4'(FILT_LEN - 1)) begin
            f_d[l][i] = s2_q[l][i];
          end else begin
            fcnt_d[l][i] = fcnt_q[l][i] + 4'd1;
          end
        end
      end

      // Arbiter: lowest enabled port currently seen low.
      req[l]  = port_en & ~f_q[l];
      cand[l] = '0;
      for (int i = NPORT - 1; i >= 0; i--) begin
        if (req[l][i]) cand[l] = OW'(i);
      end

      state_d[l] = state_q[l];
      owner_d[l] = owner_q[l];
      drv_d[l]   = drv_q[l];
      lcnt_d[l]  = lcnt_q[l];
      hcnt_d[l]  = hcnt_q[l];

      case (state_q[l])
        ST_IDLE: begin
          drv_d[l] = '0;
          if (|req[l]) begin
            owner_d[l] = cand[l];
            drv_d[l]   = port_en & ~(NPORT'(1) << cand[l]);
            lcnt_d[l]  = '0;
            state_d[l] = ST_OWN;
          end
        end
        ST_OWN: begin
          // A port disabled mid-transfer is released on the next edge.
          drv_d[l] = drv_q[l] & port_en;
          if (f_q[l][owner_q[l]] || !port_en[owner_q[l]]) begin
            drv_d[l]   = '0;
            hcnt_d[l]  = '0;
            state_d[l] = ST_HOLD;
          end else if ((TOUT_CYC != 0) && (lcnt_q[l] >= 32'(TOUT_CYC - 1))) begin
            drv_d[l]   = '0;
            tout_d[l]  = 1'b1;
            hcnt_d[l]  = '0;
            state_d[l] = ST_HOLD;
          end else if (lcnt_q[l] != '1) begin
            lcnt_d[l] = lcnt_q[l] + 32'd1;
          end
        end
        ST_HOLD: begin
          drv_d[l] = '0;
          if (hcnt_q[l] >= 32'(HOLD_CYC - 1)) begin
            state_d[l] = ST_IDLE;
          end else if (hcnt_q[l] != '1) begin
            hcnt_d[l] = hcnt_q[l] + 32'd1;
          end
        end
        default: begin
          drv_d[l]   = '0;
          state_d[l] = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int l = 0; l < NL; l++) begin
        s1_q[l]    <= '1;
        s2_q[l]    <= '1;
        f_q[l]     <= '1;
        for (int i = 0; i < NPORT; i++) fcnt_q[l][i] <= 4'd0;
        state_q[l] <= ST_IDLE;
        owner_q[l] <= '0;
        drv_q[l]   <= '0;
        lcnt_q[l]  <= '0;
        hcnt_q[l]  <= '0;
      end
      tout_q <= 2'b00;
    end else begin
      for (int l = 0; l < NL; l++) begin
        s1_q[l]    <= s1_d[l];
        s2_q[l]    <= s2_d[l];
        f_q[l]     <= f_d[l];
        for (int i = 0; i < NPORT; i++) fcnt_q[l][i] <= fcnt_d[l][i];
        state_q[l] <= state_d[l];
        owner_q[l] <= owner_d[l];
        drv_q[l]   <= drv_d[l];
        lcnt_q[l]  <= lcnt_d[l];
        hcnt_q[l]  <= hcnt_d[l];
      end
      tout_q <= tout_d;
    end
  end

  // Open-drain pads: drive 0 or float, never 1.
  for (genvar g = 0; g < NPORT; g++) begin : g_pad
    assign scl[g] = drv_q[0][g] ? 1'b0 : 1'bz;
    assign sda[g] = drv_q[1][g] ? 1'b0 : 1'bz;
  end

  assign scl_busy   = (state_q[0] != ST_IDLE);
  assign sda_busy   = (state_q[1] != ST_IDLE);
  assign scl_owner  = owner_q[0];
  assign sda_owner  = owner_q[1];
  assign tout_pulse = tout_q;

endmodule

// File: tb/tb_i2c_bypass_nport.sv
// ----------------------------------------------------------------------------
// tb_i2c_bypass_nport
//   Directed bench for i2c_bypass_nport with NPORT=4, FILT_LEN=3, HOLD_CYC=4,
//   TOUT_CYC=100. Each segment has a device model that pulls its pin low or
//   floats it; the nets are pulled high.
// ----------------------------------------------------------------------------
module tb_i2c_bypass_nport;

  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NP-1:0] port_en = '1;
  logic [NP-1:0] dev_scl = '1;
  logic [NP-1:0] dev_sda = '1;
  tri1  [NP-1:0] scl_w;
  tri1  [NP-1:0] sda_w;
  logic          scl_busy, sda_busy;
  logic [1:0]    scl_owner, sda_owner;
  logic [1:0]    tout_pulse;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NP; g++) begin : g_dev
    assign scl_w[g] = dev_scl[g] ? 1'bz : 1'b0;
    assign sda_w[g] = dev_sda[g] ? 1'bz : 1'b0;
  end

  i2c_bypass_nport #(
    .NPORT(NP), .FILT_LEN(3), .HOLD_CYC(4), .TOUT_CYC(100)
  ) dut (
    .clk(clk), .reset_n(reset_n), .port_en(port_en),
    .scl(scl_w), .sda(sda_w),
    .scl_busy(scl_busy), .sda_busy(sda_busy),
    .scl_owner(scl_owner), .sda_owner(sda_owner),
    .tout_pulse(tout_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [99:0] pat;
  int          n;
  logic        seen;

  initial begin
    pat = 100'hA5C396F01E2D3C4B5A6978E1D;

    // Reset state
    tick(3);
    chk("rst_scl_busy", scl_busy, 0);
    chk("rst_sda_busy", sda_busy, 0);
    chk("rst_owner", {scl_owner, sda_owner}, 0);
    chk("rst_tout", tout_pulse, 0);
    chk("rst_pins", {scl_w, sda_w}, 8'hFF);
    reset_n = 1'b1;
    tick(2);

    // T1: 2-port SDA transfer, latency and hold
    port_en = 4'b0011;
    dev_sda[0] = 1'b0;
    tick(5);
    chk("t1_pre_drive", sda_w[1], 1);
    chk("t1_pre_busy", sda_busy, 0);
    tick(1);
    chk("t1_drive", sda_w[1], 0);
    chk("t1_owner", sda_owner, 0);
    chk("t1_busy", sda_busy, 1);
    chk("t1_disabled_pin", sda_w[2], 1);
    tick(14);
    dev_sda[0] = 1'b1;
    tick(5);
    chk("t1_rel_early", sda_w[1], 0);
    tick(1);
    chk("t1_rel", sda_w[1], 1);
    chk("t1_hold_busy", sda_busy, 1);
    tick(3);
    chk("t1_hold_end_m1", sda_busy, 1);
    tick(1);
    chk("t1_idle", sda_busy, 0);
    tick(10);

    // T2: simultaneous SCL lows on ports 2 and 3
    port_en = 4'b1111;
    dev_scl[2] = 1'b0;
    dev_scl[3] = 1'b0;
    tick(6);
    chk("t2_owner", scl_owner, 2);
    chk("t2_busy", scl_busy, 1);
    chk("t2_pins01", {scl_w[1], scl_w[0]}, 2'b00);
    dev_scl[3] = 1'b1;
    tick(2);
    chk("t2_loser_driven", scl_w[3], 0);
    dev_scl[2] = 1'b1;
    #1;
    chk("t2_owner_not_driven", scl_w[2], 1);
    tick(20);
    chk("t2_released", {scl_w, scl_busy}, 5'b11110);

    // T3: 2-cycle glitch is filtered, 3-cycle low is accepted
    dev_sda[1] = 1'b0;
    tick(2);
    dev_sda[1] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (sda_busy || sda_w[0] == 1'b0 || sda_w[2] == 1'b0 || sda_w[3] == 1'b0) seen = 1'b1;
    end
    chk("t3_glitch_ignored", seen, 0);
    dev_sda[1] = 1'b0;
    tick(3);
    dev_sda[1] = 1'b1;
    tick(3);
    chk("t3_min_low_busy", sda_busy, 1);
    chk("t3_min_low_drive", sda_w[0], 0);
    tick(20);
    chk("t3_idle", sda_busy, 0);

    // T4: stuck-low SCL owner times out after 100 cycles and is re-captured
    port_en = 4'b0011;
    dev_scl[1] = 1'b0;
    tick(6);
    chk("t4_owner", scl_owner, 1);
    n = 0;
    while (!tout_pulse[0] && n < 200) begin
      tick(1);
      n++;
    end
    chk("t4_tout_latency", n, 100);
    chk("t4_pin0_released", scl_w[0], 1);
    chk("t4_sda_tout", tout_pulse[1], 0);
    chk("t4_hold_busy", scl_busy, 1);
    tick(1);
    chk("t4_pulse_width", tout_pulse[0], 0);
    tick(3);
    chk("t4_idle", scl_busy, 0);
    tick(1);
    chk("t4_recapture", {scl_busy, scl_owner, scl_w[0]}, 4'b1010);
    dev_scl[1] = 1'b1;
    tick(20);

    // T5: port 2 disabled during a port0 SDA transfer
    port_en = 4'b1111;
    dev_sda[0] = 1'b0;
    tick(6);
    chk("t5_pin2_driven", sda_w[2], 0);
    port_en = 4'b1011;
    tick(1);
    chk("t5_pin2_released", sda_w[2], 1);
    chk("t5_others_driven", {sda_w[3], sda_w[1]}, 2'b00);
    dev_sda[0] = 1'b1;
    tick(20);
    dev_sda[2] = 1'b0;
    tick(12);
    chk("t5_idle_ignore", {sda_busy, sda_w[0], sda_w[1], sda_w[3]}, 4'b0111);
    dev_sda[2] = 1'b1;
    tick(10);

    // T6: reset during OWN, then a 100-bit transfer across ports 0 and 1
    port_en = 4'b0011;
    dev_sda[0] = 1'b0;
    tick(8);
    chk("t6_own", {sda_busy, sda_w[1]}, 2'b10);
    reset_n = 1'b0;
    tick(1);
    chk("t6_rst_pins", {scl_w, sda_w}, 8'hFE);
    chk("t6_rst_busy", {scl_busy, sda_busy}, 0);
    dev_sda[0] = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(10);
    for (int b = 0; b < 100; b++) begin
      int s;
      s = (b < 64) ? 0 : 1;
      dev_scl[0] = 1'b0;
      dev_sda[s] = pat[b];
      tick(12);
      chk("t6_bit", {scl_w[1], sda_w[1 - s]}, {1'b0, pat[b]});
      dev_scl[0] = 1'b1;
      dev_sda[s] = 1'b1;
      tick(14);
    end
    chk("t6_end_idle", {scl_busy, sda_busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
